wb2lb_bridge: RTL

//  Wishbone classic slave that terminates cycles from the bus master (CPU or bench BFM) and turns them into

---
 rtl/wb2lb_pkg.sv | 5 +
 rtl/wb2lb_bridge.sv | 88 ++++++++
 2 files changed

// File: rtl/wb2lb_pkg.sv
// wb2lb_pkg: shared state encoding and default timeout for the Wishbone to local-bus bridge.
package wb2lb_pkg;
    typedef enum logic [1:0] {IDLE, WR, RD, ACK} state_t;
    localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/wb2lb_bridge.sv
// wb2lb_bridge: Wishbone classic slave that turns bus cycles into held local-bus write/read requests,
// with stall, per-request timeout and cycle-abort handling.
module wb2lb_bridge
    import wb2lb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int STRB_W  = DATA_W / 8,
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic [STRB_W-1:0] wb_sel_i,
    output logic [DATA_W-1:0] wb_dat_o,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] lb_waddr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic [STRB_W-1:0] lb_wstrb,
    output logic              lb_wen,
    input  logic              lb_wready,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_ren,
    input  logic [DATA_W-1:0] lb_rdata,
    input  logic              lb_rvalid
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT);
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          w_expired;
    // A completing handshake wins over an expiry landing in the same cycle.
    assign w_expired = (TIMEOUT != 0) && (r_cnt == T_MAX);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            lb_waddr <= '0;
            lb_wdata <= '0;
            lb_wstrb <= '0;
            lb_wen   <= 1'b0;
            lb_raddr <= '0;
            lb_ren   <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            case (r_state)
                IDLE: if (wb_cyc_i && wb_stb_i) begin
                    lb_waddr <= wb_adr_i;
                    lb_raddr <= wb_adr_i;
                    lb_wdata <= wb_dat_i;
                    lb_wstrb <= wb_sel_i;
                    lb_wen   <= wb_we_i;
                    lb_ren   <= !wb_we_i;
                    r_cnt    <= '0;
                    r_state  <= wb_we_i ? WR : RD;
                end
                WR: if (!wb_cyc_i) begin
                    lb_wen  <= 1'b0;
                    r_state <= IDLE;
                end else if (lb_wready || w_expired) begin
                    lb_wen   <= 1'b0;
                    wb_ack_o <= 1'b1;
                    r_state  <= ACK;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                RD: if (!wb_cyc_i) begin
                    lb_ren  <= 1'b0;
                    r_state <= IDLE;
                end else if (lb_rvalid || w_expired) begin
                    lb_ren   <= 1'b0;
                    wb_dat_o <= lb_rvalid ? lb_rdata : '0;
                    wb_ack_o <= 1'b1;
                    r_state  <= ACK;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
